seg7_scan: RTL and testbench

- Display-side companion to the stopwatch.
- Consumes the four 7-segment digit patterns and the s_run/s_hld indicators.
- Drives one shared, time-multiplexed 4-digit LED display with per-digit anti-ghosting blanking.
- Drives a colon/decimal point that shows run and hold status.
- Sits between the stopwatch core and the board pins.

---
 rtl/seg7_scan.sv | 123 ++++++++++++
 tb/tb_seg7_scan.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-slot blanking and a status colon.
// Optional leading-zero blanking of the tens-of-minutes digit: define SEG7_SCAN_LZB_EN.
module seg7_scan #(
  parameter int unsigned SPD     = 6000,
  parameter int unsigned BLK     = 16,
  parameter int unsigned BPN     = 6_000_000,
  parameter logic        SEG_POL = 1'b0,
  parameter logic        DIG_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sec_0,
  input  logic [6:0] sec_1,
  input  logic [6:0] min_0,
  input  logic [6:0] min_1,
  input  logic       s_run,
  input  logic       s_hld,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig
);

  localparam int unsigned CW = (SPD > 1) ? $clog2(SPD) : 1;
  localparam int unsigned BW = (BPN > 1) ? $clog2(BPN) : 1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [6:0]    r_snap;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          r_hld_d;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [3:0]    r_dig;

  logic [6:0]    w_pat;
  logic          w_blank;
  logic          w_dp_on;
  logic          w_hld_rise;
  logic          w_lzb;

  always_comb begin
    w_pat = sec_0;
    case (r_idx)
      2'd0:    w_pat = sec_0;
      2'd1:    w_pat = sec_1;
      2'd2:    w_pat = min_0;
      default: w_pat = min_1;
    endcase
  end

  assign w_blank    = (r_cnt < CW'(BLK));
  assign w_hld_rise = s_hld & ~r_hld_d;
  assign w_dp_on    = s_hld ? r_phase : s_run;

`ifdef SEG7_SCAN_LZB_EN
  assign w_lzb = (r_idx == 2'd3) && (r_snap == 7'h3F);
`else
  assign w_lzb = 1'b0;
`endif

  // Slot counter, digit index and per-slot snapshot of the selected pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_snap <= 7'h00;
    end else begin
      if (r_cnt == '0) r_snap <= w_pat;
      if (r_cnt == CW'(SPD - 1)) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Hold-mode blink timer, restarted in the on phase at each hold entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
      r_hld_d <= 1'b0;
    end else begin
      r_hld_d <= s_hld;
      if (w_hld_rise) begin
        r_bcnt  <= '0;
        r_phase <= 1'b1;
      end else if (r_bcnt == BW'(BPN - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end

  // Registered pin drive; everything idles inactive unless in an active window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= {7{~SEG_POL}};
      r_dp  <= ~SEG_POL;
      r_dig <= {4{~DIG_POL}};
    end else begin
      r_seg <= {7{~SEG_POL}};
      r_dp  <= ~SEG_POL;
      r_dig <= {4{~DIG_POL}};
      if (!w_blank) begin
        if ((r_idx == 2'd2) && w_dp_on) r_dp <= SEG_POL;
        if (!w_lzb) begin
          r_seg        <= r_snap ^ {7{~SEG_POL}};
          r_dig[r_idx] <= DIG_POL;
        end
      end
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign dig = r_dig;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan against a slot-arithmetic reference model.
module tb_seg7_scan;

  localparam int unsigned SPD = 8;
  localparam int unsigned BLK = 2;
  localparam int unsigned BPN = 20;
  localparam int unsigned PER = 4 * SPD;
`ifdef SEG7_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk, clk_en, rst;
  logic [6:0] sec_0, sec_1, min_0, min_1;
  logic       s_run, s_hld;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig;

  int checks = 0;
  int fails  = 0;

  seg7_scan #(
    .SPD(SPD), .BLK(BLK), .BPN(BPN), .SEG_POL(1'b0), .DIG_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .sec_0(sec_0), .sec_1(sec_1), .min_0(min_0), .min_1(min_1),
    .s_run(s_run), .s_hld(s_hld), .seg(seg), .dp(dp), .dig(dig)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model: position in the refresh frame is derived from edges since reset
  int         mk = 0;
  int         bt = 0;
  int         mc, md;
  bit         hprev = 1'b0;
  logic [6:0] m_snap [4];
  logic [3:0] e_dig = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp  = 1'b1;

  function automatic logic [6:0] cur_pat(input int d);
    case (d)
      0:       return sec_0;
      1:       return sec_1;
      2:       return min_0;
      default: return min_1;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk = 0; bt = 0; hprev = 1'b0;
      e_dig = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      mc = mk % SPD;
      md = (mk / SPD) % 4;
      if (mc == 0) m_snap[md] = cur_pat(md);
      e_dig = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (mc >= BLK) begin
        if (md == 2 && (s_hld ? (((bt / BPN) % 2) == 0) : s_run)) e_dp = 1'b0;
        if (!(LZB && md == 3 && m_snap[3] == 7'h3F)) begin
          e_dig = 4'(~(4'b0001 << md));
          e_seg = ~m_snap[md];
        end
      end
      bt = (s_hld && !hprev) ? 0 : bt + 1;
      hprev = s_hld;
      mk++;
    end
  end

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (dig !== 4'hF)  begin fails++; $display("FAIL rst_async_dig got=%b exp=1111", dig); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL rst_async_seg got=%h exp=7f", seg); end
    checks++; if (dp !== 1'b1)   begin fails++; $display("FAIL rst_async_dp got=%b exp=1", dp); end
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SPD; i++) begin
      @(negedge clk);
      checks++;
      if (i < BLK) begin
        if (dig !== 4'hF) begin fails++; $display("FAIL rst_rel_blank i=%0d got=%b exp=1111", i, dig); end
      end else begin
        if (dig !== 4'b1110) begin fails++; $display("FAIL rst_rel_dig i=%0d got=%b exp=1110", i, dig); end
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    exp_seg[0] = 7'h79; exp_seg[1] = 7'h24; exp_seg[2] = 7'h30; exp_seg[3] = 7'h19;
    sec_0 = 7'h06; sec_1 = 7'h5B; min_0 = 7'h4F; min_1 = 7'h66;
    s_run = 1'b0; s_hld = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 40 && (mk % PER) != 0; g++) @(negedge clk);
    for (int i = 0; i < int'(PER); i++) begin
      logic [3:0] xd;
      logic [6:0] xs;
      @(negedge clk);
      xd = 4'hF; xs = 7'h7F;
      if ((i % SPD) >= BLK) begin
        xd = 4'(~(4'b0001 << (i / SPD)));
        xs = exp_seg[i / SPD];
      end
      checks++; if (dig !== xd) begin fails++; $display("FAIL scan_dig i=%0d got=%b exp=%b", i, dig, xd); end
      checks++; if (seg !== xs) begin fails++; $display("FAIL scan_seg i=%0d got=%h exp=%h", i, seg, xs); end
      checks++; if (dp !== 1'b1) begin fails++; $display("FAIL scan_dp i=%0d got=%b exp=1", i, dp); end
    end
  endtask

  task automatic test_snapshot();
    sec_0 = 7'h06;
    for (int g = 0; g < 40 && (mk % PER) != 4; g++) @(negedge clk);
    sec_0 = 7'h3F;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4) begin
        checks++; if (seg !== 7'h79) begin fails++; $display("FAIL snap_hold i=%0d got=%h exp=79", i, seg); end
      end
      if (i >= 30 && i < 36) begin
        checks++; if (seg !== 7'h40) begin fails++; $display("FAIL snap_next i=%0d got=%h exp=40", i, seg); end
      end
      checks++; if (dig !== e_dig) begin fails++; $display("FAIL snap_dig i=%0d got=%b exp=%b", i, dig, e_dig); end
    end
  endtask

  task automatic test_status();
    s_run = 1'b1; s_hld = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 40 && (mk % PER) != 0; g++) @(negedge clk);
    for (int i = 0; i < int'(PER); i++) begin
      logic xp;
      @(negedge clk);
      xp = (i >= 18 && i < 24) ? 1'b0 : 1'b1;
      checks++; if (dp !== xp) begin fails++; $display("FAIL run_dp i=%0d got=%b exp=%b", i, dp, xp); end
    end
    s_hld = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      checks++; if (dp !== e_dp)   begin fails++; $display("FAIL hold_dp i=%0d got=%b exp=%b", i, dp, e_dp); end
      checks++; if (dig !== e_dig) begin fails++; $display("FAIL hold_dig i=%0d got=%b exp=%b", i, dig, e_dig); end
    end
    s_run = 1'b0; s_hld = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (dp !== 1'b1) begin fails++; $display("FAIL idle_dp i=%0d got=%b exp=1", i, dp); end
    end
  endtask

  task automatic test_mid_reset();
    for (int g = 0; g < 40 && (mk % PER) != 22; g++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (dig !== 4'hF)  begin fails++; $display("FAIL midrst_dig got=%b exp=1111", dig); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL midrst_seg got=%h exp=7f", seg); end
    checks++; if (dp !== 1'b1)   begin fails++; $display("FAIL midrst_dp got=%b exp=1", dp); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < SPD; i++) begin
      logic [3:0] xd;
      @(negedge clk);
      xd = (i < BLK) ? 4'hF : 4'b1110;
      checks++; if (dig !== xd)    begin fails++; $display("FAIL midrst_rel_dig i=%0d got=%b exp=%b", i, dig, xd); end
      checks++; if (seg !== e_seg) begin fails++; $display("FAIL midrst_rel_seg i=%0d got=%h exp=%h", i, seg, e_seg); end
    end
  endtask

  task automatic test_lzb();
    min_1 = 7'h3F;
    for (int g = 0; g < 40 && (mk % PER) != 0; g++) @(negedge clk);
    for (int i = 0; i < int'(PER); i++) begin
      @(negedge clk);
      if (i >= 26) begin
        checks++;
        if (LZB) begin
          if (dig !== 4'hF || seg !== 7'h7F) begin
            fails++; $display("FAIL lzb_zero i=%0d got=%b/%h exp=1111/7f", i, dig, seg);
          end
        end else if (dig !== 4'b0111 || seg !== 7'h40) begin
          fails++; $display("FAIL lzb_zero i=%0d got=%b/%h exp=0111/40", i, dig, seg);
        end
      end
      checks++; if (dig !== e_dig) begin fails++; $display("FAIL lzb_dig i=%0d got=%b exp=%b", i, dig, e_dig); end
    end
    min_1 = 7'h06;
    @(negedge clk);
    for (int g = 0; g < 40 && (mk % PER) != 0; g++) @(negedge clk);
    for (int i = 0; i < int'(PER); i++) begin
      @(negedge clk);
      if (i >= 26) begin
        checks++;
        if (dig !== 4'b0111 || seg !== 7'h79) begin
          fails++; $display("FAIL lzb_one i=%0d got=%b/%h exp=0111/79", i, dig, seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++; if (dig !== e_dig) begin fails++; $display("FAIL rand_dig i=%0d got=%b exp=%b", i, dig, e_dig); end
      checks++; if (seg !== e_seg) begin fails++; $display("FAIL rand_seg i=%0d got=%h exp=%h", i, seg, e_seg); end
      checks++; if (dp !== e_dp)   begin fails++; $display("FAIL rand_dp i=%0d got=%b exp=%b", i, dp, e_dp); end
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0:       sec_0 = 7'($urandom);
          1:       sec_1 = 7'($urandom);
          2:       min_0 = 7'($urandom);
          default: min_1 = ($urandom_range(1) == 0) ? 7'h3F : 7'($urandom);
        endcase
      end
      if ($urandom_range(15) == 0) s_run = ~s_run;
      if ($urandom_range(29) == 0) s_hld = ~s_hld;
    end
  endtask

  initial begin
    clk = 1'b0; clk_en = 1'b0; rst = 1'b0;
    sec_0 = 7'h00; sec_1 = 7'h00; min_0 = 7'h00; min_1 = 7'h00;
    s_run = 1'b0; s_hld = 1'b0;
    test_reset();
    test_scan();
    test_snapshot();
    test_status();
    test_mid_reset();
    test_lzb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
